div_ctrl: RTL and testbench

- Multi-cycle divide sequencer for the EX stage of the 5-stage MIPS pipeline.
- Accepts a DIV/DIVU request from EX and runs a radix-2 restoring divide: one quotient bit per cycle, with sign pre/post fix.
- Drives the divider stall that the hazard unit consumes as stall_divE.
- Holds the quotient/remainder stable until the EX stage advances; the quotient and remainder feed the HI/LO writeback.

---
 rtl/div_ctrl_if.sv | 28 ++
 rtl/div_ctrl.sv | 129 ++++++++++++
 tb/tb_div_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage request/result bundle for the divide sequencer.
//   master (EX stage / bench): start, is_signed, a, b, cancel, e_hold
//   slave  (div_ctrl)        : stall_div, busy, valid, quot, rem
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             e_hold;
  logic             stall_div;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (
    output start, is_signed, a, b, cancel, e_hold,
    input  stall_div, busy, valid, quot, rem
  );

  modport slave (
    input  start, is_signed, a, b, cancel, e_hold,
    output stall_div, busy, valid, quot, rem
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
//   clk    : pipeline clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : div_ctrl_if.slave
//     in : start (level), is_signed, a (dividend), b (divisor),
//          cancel (flush), e_hold (EX held by something else)
//     out: stall_div (to hazard unit), busy (RUN/FIX), valid (DONE),
//          quot (LO), rem (HI)
// Latency: accept, WIDTH RUN cycles, FIX, then DONE.
// Optional: `define DIV_EARLY_ZERO_EN to finish a=0 or b=0 straight from accept.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;     // |a|, shifts out as quotient bits shift in
  logic [WIDTH-1:0] dsr;     // |b|
  logic [WIDTH-1:0] prem;    // partial remainder
  logic [WIDTH-1:0] a_orig;  // raw dividend, returned as rem on divide-by-zero
  logic             sa, sb;  // operand signs, already masked by is_signed
  logic             dz;
  logic [WIDTH-1:0] quot_r, rem_r;

  logic             accept;
  logic             zero_op;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  assign accept = (state == IDLE) && bus.start && !bus.cancel;

`ifdef DIV_EARLY_ZERO_EN
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // {rem,dividend} << 1; since prem < dsr the difference always fits in
  // WIDTH bits, so the WIDTH+1-bit trial reduces to compare + subtract.
  assign sh   = {prem, dvd[WIDTH-1]};
  assign ge   = sh >= {1'b0, dsr};
  assign diff = sh[WIDTH-1:0] - dsr;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    if (bus.cancel) nxt = IDLE;
    else begin
      unique case (state)
        IDLE: if (bus.start) nxt = zero_op ? DONE : RUN;
        RUN:  if (cnt == '0) nxt = FIX;
        FIX:  nxt = DONE;
        DONE: if (!bus.e_hold) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    bus.busy      = (state == RUN) || (state == FIX);
    bus.stall_div = (accept || state == RUN || state == FIX) && !bus.cancel;
    bus.valid     = (state == DONE) && !bus.cancel;
    bus.quot      = quot_r;
    bus.rem       = rem_r;
  end

  // datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      prem   <= '0;
      a_orig <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      if (accept) begin
        sa     <= bus.is_signed & bus.a[WIDTH-1];
        sb     <= bus.is_signed & bus.b[WIDTH-1];
        dvd    <= (bus.is_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        dsr    <= (bus.is_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        a_orig <= bus.a;
        dz     <= (bus.b == '0);
        prem   <= '0;
        cnt    <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_ZERO_EN
        if (bus.b == '0) begin
          quot_r <= '1;
          rem_r  <= bus.a;
        end else if (bus.a == '0) begin
          quot_r <= '0;
          rem_r  <= '0;
        end
`endif
      end else if (state == RUN) begin
        dvd  <= {dvd[WIDTH-2:0], ge};
        prem <= ge ? diff : sh[WIDTH-1:0];
        cnt  <= cnt - 1'b1;
      end else if (state == FIX && !bus.cancel) begin
        if (dz) begin
          quot_r <= '1;
          rem_r  <= a_orig;
        end else begin
          quot_r <= (sa ^ sb) ? -dvd : dvd;
          rem_r  <= sa ? -prem : prem;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  div_ctrl_if #(.WIDTH(W)) bus();
  div_ctrl #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        s;
    logic [31:0] a, b, q, r;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_ZERO_EN
    return (a == 0 || b == 0) ? 1 : 34;
`else
    return (a == 0 && b == 0) ? 34 : 34;
`endif
  endfunction

  // Present a request at a falling edge and count cycles with stall_div high.
  // Returns #1 after the edge that ends the stall (i.e. inside DONE).
  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = s; bus.a = a; bus.b = b;
    #1;
    lat = 0;
    while (bus.stall_div === 1'b1 && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
  endtask

  int lat;

  initial begin
    vt[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vt[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vt[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0};
    vt[3]  = '{1'b0, 32'h1234,       32'h0,          32'hFFFF_FFFF,  32'h1234};
    vt[4]  = '{1'b1, 32'hFFFF_FFF9,  32'h0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
    vt[5]  = '{1'b0, 32'h0,          32'd5,          32'h0,          32'h0};
    vt[6]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0};
    vt[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'h0};
    vt[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'h0};
    vt[9]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vt[10] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vt[11] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
    vt[12] = '{1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2};
    vt[13] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    bus.cancel = 1'b0; bus.e_hold = 1'b0;
    resetn = 1'b0;
    #12;
    chk("rst stall", {31'b0, bus.stall_div}, 32'd0);
    chk("rst busy",  {31'b0, bus.busy},      32'd0);
    chk("rst valid", {31'b0, bus.valid},     32'd0);
    chk("rst quot",  bus.quot, 32'd0);
    chk("rst rem",   bus.rem,  32'd0);
    @(negedge clk); resetn = 1'b1;

    // table of directed divides
    for (int i = 0; i < 14; i++) begin
      go(vt[i].s, vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d lat", i),   lat, exp_lat(vt[i].a, vt[i].b));
      chk($sformatf("v%0d valid", i), {31'b0, bus.valid}, 32'd1);
      chk($sformatf("v%0d quot", i),  bus.quot, vt[i].q);
      chk($sformatf("v%0d rem", i),   bus.rem,  vt[i].r);
      bus.start = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'd1;
      @(posedge clk); #1;
      chk($sformatf("v%0d idle valid", i), {31'b0, bus.valid}, 32'd0);
      chk($sformatf("v%0d idle busy", i),  {31'b0, bus.busy},  32'd0);
    end

    // DONE hold: start stays high and operands change, nothing restarts
    go(1'b0, 32'd100, 32'd7, lat);
    chk("hold lat", lat, 32'd34);
    bus.e_hold = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d valid", k), {31'b0, bus.valid},     32'd1);
      chk($sformatf("hold%0d stall", k), {31'b0, bus.stall_div}, 32'd0);
      chk($sformatf("hold%0d quot", k),  bus.quot, 32'd14);
      chk($sformatf("hold%0d rem", k),   bus.rem,  32'd2);
      @(posedge clk); #1;
    end
    chk("hold end valid", {31'b0, bus.valid}, 32'd1);
    bus.e_hold = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("hold release valid", {31'b0, bus.valid}, 32'd0);
    chk("hold release busy",  {31'b0, bus.busy},  32'd0);

    // cancel at RUN cycle 10, start held through the cancel
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd50; bus.b = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    chk("cxl pre busy", {31'b0, bus.busy}, 32'd1);
    bus.cancel = 1'b1;
    #1;
    chk("cxl stall", {31'b0, bus.stall_div}, 32'd0);
    chk("cxl valid", {31'b0, bus.valid},     32'd0);
    @(posedge clk); #1;
    chk("cxl idle busy",  {31'b0, bus.busy},      32'd0);
    chk("cxl idle stall", {31'b0, bus.stall_div}, 32'd0);
    bus.cancel = 1'b0; bus.start = 1'b0;
    go(1'b0, 32'd9, 32'd3, lat);
    chk("cxl new lat",  lat, 32'd34);
    chk("cxl new quot", bus.quot, 32'd3);
    chk("cxl new rem",  bus.rem,  32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // async reset mid-RUN after a result with nonzero quot is held
    go(1'b0, 32'd100, 32'd7, lat);
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd77; bus.b = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    chk("rrun busy", {31'b0, bus.busy}, 32'd1);
    #2;
    resetn = 1'b0; bus.start = 1'b0;
    #1;
    chk("rrun stall", {31'b0, bus.stall_div}, 32'd0);
    chk("rrun busy0", {31'b0, bus.busy},      32'd0);
    chk("rrun valid", {31'b0, bus.valid},     32'd0);
    chk("rrun quot",  bus.quot, 32'd0);
    chk("rrun rem",   bus.rem,  32'd0);
    @(negedge clk); resetn = 1'b1;
    go(1'b0, 32'd100, 32'd7, lat);
    chk("post rst lat",  lat, 32'd34);
    chk("post rst quot", bus.quot, 32'd14);
    chk("post rst rem",  bus.rem,  32'd2);
    bus.start = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
